// File: rtl/ysyx_24090018_inst_seq_pkg.sv
// Shared defines for the NPC instruction sequencer: RV32I opcodes, the ebreak
// encoding and the sequencer state encoding.
package ysyx_24090018_inst_seq_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [31:0] INST_EBREAK = 32'h00100073;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_IWAIT,
    ST_DECODE,
    ST_EXEC,
    ST_MREQ,
    ST_MWAIT,
    ST_WB,
    ST_HALT
  } state_t;

endpackage

// File: rtl/ysyx_24090018_inst_seq_class.sv
// Combinational instruction classifier for the sequencer: memory-access type,
// ebreak detection, register write-back and opcode legality.
module ysyx_24090018_inst_class
  import ysyx_24090018_inst_seq_pkg::*;
(
  input  logic [31:0] inst_o,
  output logic        is_load,
  output logic        is_store,
  output logic        is_ebreak,
  output logic        writes_rd,
  output logic        is_legal
);

  logic [6:0] opcode;

  assign opcode = inst_o[6:0];

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    writes_rd = 1'b0;
    is_legal  = 1'b0;
    is_ebreak = (inst_o == INST_EBREAK);
    case (opcode)
      OPC_LOAD: begin
        is_load   = 1'b1;
        writes_rd = 1'b1;
        is_legal  = 1'b1;
      end
      OPC_STORE: begin
        is_store = 1'b1;
        is_legal = 1'b1;
      end
      OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: begin
        writes_rd = 1'b1;
        is_legal  = 1'b1;
      end
      OPC_BRANCH: is_legal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_24090018_inst_seq.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, memory, write-back.
// Define YSYX_24090018_ILLEGAL_TRAP_EN to halt on unsupported opcodes.
module ysyx_24090018_inst_seq
  import ysyx_24090018_inst_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req_o,
  input  logic        ifu_ready_i,
  input  logic        ifu_rvalid_i,
  input  logic [31:0] ifu_rdata_i,
  output logic [31:0] inst_o,
  output logic        lsu_req_o,
  output logic        lsu_wen_o,
  input  logic        lsu_ready_i,
  input  logic        lsu_rvalid_i,
  output logic        rf_we_o,
  output logic        pc_we_o,
  output logic        commit_o,
  output logic        halt_o,
  output logic        illegal_o
);

  state_t state, state_next;
  logic   is_load, is_store, is_ebreak, writes_rd, is_legal;

  ysyx_24090018_inst_class u_class (
    .inst_o    (inst_o),
    .is_load   (is_load),
    .is_store  (is_store),
    .is_ebreak (is_ebreak),
    .writes_rd (writes_rd),
    .is_legal  (is_legal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_o <= '0;
    end else if (state == ST_IWAIT && ifu_rvalid_i) begin
      inst_o <= ifu_rdata_i;
    end
  end

`ifdef YSYX_24090018_ILLEGAL_TRAP_EN
  logic trap;
  logic illegal_q;

  assign trap = !is_ebreak && !is_legal;

  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else if (state == ST_DECODE && trap) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal_o = illegal_q;
`else
  logic trap;
  logic unused_is_legal;

  // Unsupported opcodes fall through EXEC/WB as NOPs (writes_rd is 0 for them).
  assign trap            = 1'b0;
  assign unused_is_legal = is_legal;
  assign illegal_o       = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      ST_FETCH:  if (ifu_ready_i) state_next = ST_IWAIT;
      ST_IWAIT:  if (ifu_rvalid_i) state_next = ST_DECODE;
      ST_DECODE: state_next = (is_ebreak || trap) ? ST_HALT : ST_EXEC;
      ST_EXEC:   state_next = (is_load || is_store) ? ST_MREQ : ST_WB;
      ST_MREQ:   if (lsu_ready_i) state_next = ST_MWAIT;
      ST_MWAIT:  if (lsu_rvalid_i) state_next = ST_WB;
      ST_WB:     state_next = ST_FETCH;
      ST_HALT:   state_next = ST_HALT;
      default:   state_next = ST_FETCH;
    endcase
  end

  always_comb begin
    ifu_req_o = 1'b0;
    lsu_req_o = 1'b0;
    lsu_wen_o = 1'b0;
    rf_we_o   = 1'b0;
    pc_we_o   = 1'b0;
    commit_o  = 1'b0;
    halt_o    = 1'b0;
    case (state)
      ST_FETCH: ifu_req_o = 1'b1;
      ST_MREQ: begin
        lsu_req_o = 1'b1;
        lsu_wen_o = is_store;
      end
      ST_WB: begin
        rf_we_o  = writes_rd;
        pc_we_o  = 1'b1;
        commit_o = 1'b1;
      end
      ST_HALT: halt_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_24090018_inst_seq.sv
// Directed self-checking bench for ysyx_24090018_inst_seq.
// Expectations follow YSYX_24090018_ILLEGAL_TRAP_EN when it is defined.
module tb_ysyx_24090018_inst_seq;

  logic        clk;
  logic        rst;
  logic        ifu_req_o;
  logic        ifu_ready_i;
  logic        ifu_rvalid_i;
  logic [31:0] ifu_rdata_i;
  logic [31:0] inst_o;
  logic        lsu_req_o;
  logic        lsu_wen_o;
  logic        lsu_ready_i;
  logic        lsu_rvalid_i;
  logic        rf_we_o;
  logic        pc_we_o;
  logic        commit_o;
  logic        halt_o;
  logic        illegal_o;

  int tests;
  int fails;

  ysyx_24090018_inst_seq dut (
    .clk          (clk),
    .rst          (rst),
    .ifu_req_o    (ifu_req_o),
    .ifu_ready_i  (ifu_ready_i),
    .ifu_rvalid_i (ifu_rvalid_i),
    .ifu_rdata_i  (ifu_rdata_i),
    .inst_o       (inst_o),
    .lsu_req_o    (lsu_req_o),
    .lsu_wen_o    (lsu_wen_o),
    .lsu_ready_i  (lsu_ready_i),
    .lsu_rvalid_i (lsu_rvalid_i),
    .rf_we_o      (rf_we_o),
    .pc_we_o      (pc_we_o),
    .commit_o     (commit_o),
    .halt_o       (halt_o),
    .illegal_o    (illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Packs {rf_we, pc_we, commit} so a whole WB pulse checks in one comparison.
  function automatic logic [31:0] pulses();
    return {29'd0, rf_we_o, pc_we_o, commit_o};
  endfunction

  // Starts in FETCH; zero-wait handshake; returns with the DUT in DECODE.
  task automatic fetch(input string tag, input logic [31:0] word);
    chk({tag, "_fetch_req"}, {31'd0, ifu_req_o}, 32'd1);
    ifu_ready_i = 1'b1;
    step();
    ifu_ready_i  = 1'b0;
    chk({tag, "_iwait_req"}, {31'd0, ifu_req_o}, 32'd0);
    ifu_rvalid_i = 1'b1;
    ifu_rdata_i  = word;
    step();
    ifu_rvalid_i = 1'b0;
    ifu_rdata_i  = '0;
    chk({tag, "_decode_inst"}, inst_o, word);
  endtask

  initial begin
    tests        = 0;
    fails        = 0;
    rst          = 1'b1;
    ifu_ready_i  = 1'b0;
    ifu_rvalid_i = 1'b0;
    ifu_rdata_i  = '0;
    lsu_ready_i  = 1'b0;
    lsu_rvalid_i = 1'b0;
    step();
    step();
    rst = 1'b0;

    chk("rst_inst", inst_o, 32'h0);
    chk("rst_pulses", pulses(), 32'd0);
    chk("rst_flags", {30'd0, halt_o, illegal_o}, 32'd0);
    chk("rst_lsu_req", {31'd0, lsu_req_o}, 32'd0);

    // addi: WB in cycle 5, FETCH again in cycle 6
    fetch("addi", 32'h00500093);
    step();
    chk("addi_exec_pulses", pulses(), 32'd0);
    step();
    chk("addi_wb_pulses", pulses(), 32'd7);
    step();
    chk("addi_c6_req", {31'd0, ifu_req_o}, 32'd1);
    chk("addi_c6_pulses", pulses(), 32'd0);

    // lw with lsu_ready delayed three cycles
    fetch("lw", 32'h0000a103);
    step();
    step();
    for (int unsigned i = 0; i < 4; i++) begin
      chk("lw_mreq", {30'd0, lsu_req_o, lsu_wen_o}, 32'd2);
      if (i == 3) lsu_ready_i = 1'b1;
      step();
    end
    lsu_ready_i = 1'b0;
    chk("lw_mwait_req", {31'd0, lsu_req_o}, 32'd0);
    chk("lw_mwait_pulses", pulses(), 32'd0);
    lsu_rvalid_i = 1'b1;
    step();
    lsu_rvalid_i = 1'b0;
    chk("lw_wb_pulses", pulses(), 32'd7);
    step();

    // rvalid while still in FETCH must not advance the sequencer
    ifu_rvalid_i = 1'b1;
    ifu_rdata_i  = 32'hdeadbeef;
    step();
    ifu_rvalid_i = 1'b0;
    chk("fetch_ignore_rvalid", {31'd0, ifu_req_o}, 32'd1);

    // sw: store request, no register write
    fetch("sw", 32'h0020a023);
    step();
    step();
    chk("sw_mreq", {30'd0, lsu_req_o, lsu_wen_o}, 32'd3);
    lsu_ready_i = 1'b1;
    step();
    lsu_ready_i  = 1'b0;
    lsu_rvalid_i = 1'b1;
    step();
    lsu_rvalid_i = 1'b0;
    chk("sw_wb_pulses", pulses(), 32'd3);
    step();

    // unsupported opcode
    fetch("ill", 32'h0000007f);
    step();
`ifdef YSYX_24090018_ILLEGAL_TRAP_EN
    chk("ill_flags", {30'd0, halt_o, illegal_o}, 32'd3);
    chk("ill_halt_pulses", pulses(), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("ill_rst_flags", {30'd0, halt_o, illegal_o}, 32'd0);
`else
    chk("ill_exec_flags", {30'd0, halt_o, illegal_o}, 32'd0);
    step();
    chk("ill_wb_pulses", pulses(), 32'd3);
    chk("ill_wb_illegal", {31'd0, illegal_o}, 32'd0);
    step();
`endif

    // ebreak: halted from cycle 4, no further fetch
    fetch("ebreak", 32'h00100073);
    step();
    ifu_ready_i = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      chk("ebreak_halt", {30'd0, halt_o, ifu_req_o}, 32'd2);
      chk("ebreak_pulses", pulses(), 32'd0);
      step();
    end
    ifu_ready_i = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("ebreak_rst", {30'd0, halt_o, ifu_req_o}, 32'd1);
    chk("ebreak_rst_inst", inst_o, 32'h0);

    // reset in MWAIT, stale lsu_rvalid arrives in FETCH
    fetch("lwr", 32'h0000a103);
    step();
    step();
    lsu_ready_i = 1'b1;
    step();
    lsu_ready_i = 1'b0;
    rst = 1'b1;
    step();
    rst          = 1'b0;
    lsu_rvalid_i = 1'b1;
    chk("lwr_fetch_pulses", pulses(), 32'd0);
    chk("lwr_fetch_req", {30'd0, ifu_req_o, lsu_req_o}, 32'd2);
    step();
    lsu_rvalid_i = 1'b0;
    chk("lwr_stale_pulses", pulses(), 32'd0);
    chk("lwr_still_fetch", {31'd0, ifu_req_o}, 32'd1);
    fetch("after", 32'h00500093);
    step();
    step();
    chk("after_wb_pulses", pulses(), 32'd7);
    step();
    chk("after_fetch_req", {31'd0, ifu_req_o}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
